sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, active pixels per line (legal range 3..4096).
REQ-002 SHALL have parameter DW, default 24, pixel width ({R,G,B} 8 bits each).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DIN  input  DW  raster-order input pixel.
REQ-006 SHALL have port DIN_VALID  input  1  DIN beat qualifier.
REQ-007 SHALL have port DIN_SOF  input  1  marks first pixel of frame; meaningful only with DIN_VALID.
REQ-008 SHALL have port DIN_EOL  input  1  marks last pixel of line; meaningful only with DIN_VALID.
REQ-009 SHALL have ports D02OUT, D01OUT, D00OUT  output  DW each  upper window row (row r-2), oldest to newest column.
REQ-010 SHALL have ports D12OUT, D11OUT, D10OUT  output  DW each  middle window row (row r-1).
REQ-011 SHALL have ports D22OUT, D21OUT, D20OUT  output  DW each  under window row (current row r).
REQ-012 SHALL have port DOUT_VALID  output  1  window complete and inside image.
REQ-013 SHALL have ports DOUT_SOF, DOUT_EOL  output  1 each  first window of frame / last window of line.
REQ-014 SHALL have port LEN_ERR  output  1  one-cycle pulse on line-length mismatch.

Function
REQ-015 Column counter COL SHALL advance on every DIN_VALID beat; wrap to 0 after IMG_WIDTH-1 or on a DIN_EOL beat, whichever comes first.
REQ-016 Row counter ROW SHALL increment on wrap and saturate at 2; a DIN_SOF beat SHALL force COL=0, ROW=0 for that beat.
REQ-017 Two line buffers, depth IMG_WIDTH, SHALL form a cascade: each beat at address COL reads the old word first, then writes the new one (DIN into buffer A, old A word into buffer B).
REQ-018 Line-buffer reads SHALL be synchronous with 1-cycle latency; DIN, COL and flags SHALL be registered to align with read data (stage 1).
REQ-019 Stage 2 SHALL shift the 3x3 register window one column on each aligned valid beat: new column = {B word, A word, DIN}, landing in D00/D10/D20; the old x0 column moves to x1 and x1 to x2.
REQ-020 DOUT_VALID SHALL assert exactly 2 cycles after the DIN_VALID beat whose ROW>=2 and COL>=2; no window SHALL be emitted for the first 2 rows or first 2 columns (no padding).
REQ-021 DOUT_SOF SHALL accompany the window at (ROW 2, COL 2) of a frame; DOUT_EOL SHALL accompany the window of the beat that wrapped COL.
REQ-022 DIN_VALID low SHALL freeze counters, buffers and window, and SHALL drive DOUT_VALID, DOUT_SOF and DOUT_EOL low on the corresponding output cycle; bubbles SHALL NOT change the window sequence.
REQ-023 LEN_ERR SHALL pulse (aligned with stage 2) when DIN_EOL arrives with COL != IMG_WIDTH-1, or when COL wraps at IMG_WIDTH-1 without DIN_EOL.
REQ-024 DIN_SOF together with DIN_EOL on one beat SHALL resolve as a one-pixel line: COL=0, ROW=1, with LEN_ERR.
REQ-025 There SHALL be no backpressure; the downstream filter accepts every DOUT_VALID cycle.

Reset
REQ-026 RESET low SHALL immediately clear COL, ROW, pipeline valid bits, all nine window outputs (0), DOUT_VALID, DOUT_SOF, DOUT_EOL and LEN_ERR.
REQ-027 Line-buffer contents SHALL NOT be reset; stale data is masked by ROW<2 gating.
REQ-028 Reset asserted mid-line SHALL discard the partial frame; output resumes only after 2 full rows plus 3 pixels.

Structure
REQ-029 A shared package/header SHALL hold pixel width 24, window size 3, default IMG_WIDTH 640 and the minimum-width constant 3.
REQ-030 One sub-module, sobel_line_ram (simple dual-port, 1-cycle read, read-before-write), SHALL be instantiated twice.

Verification (IMG_WIDTH=8, pixel = 24'h0000RC, where R = row and C = column)
REQ-031 8x4 ramp frame, continuous valid -> first DOUT_VALID 2 cycles after pixel (2,2), with DOUT_SOF=1, D02=000000, D00=000002, D22=000020, D20=000022; total 12 windows; DOUT_EOL on windows (2,7) and (3,7).
REQ-032 Same frame with DIN_VALID toggling 1/0 -> identical 12-window sequence, DOUT_VALID never on consecutive cycles.
REQ-033 Row 1 ends with DIN_EOL at col 5 -> LEN_ERR one pulse; row 2 starts at COL 0.
REQ-034 DIN_SOF asserted at pixel (2,4) -> no DOUT_VALID until new pixel (2,2); next window has D20=000022 of the new frame.
REQ-035 RESET pulsed at pixel (3,3) -> all outputs 0 within the same cycle; no window until 2 rows plus 3 pixels after release.
REQ-036 IMG_WIDTH=3, 3x3 frame -> exactly one window, with DOUT_SOF=DOUT_EOL=1 and D20=000022.

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the Sobel 3x3 window generator.
//   PIX_DW        : pixel width ({R,G,B}, 8 bits each)
//   WIN_SIZE      : window edge length
//   DEF_IMG_WIDTH : default active pixels per line
//   MIN_IMG_WIDTH : narrowest legal line
//   col_bits()    : column counter width for a given line length
package sobel_window_gen_pkg;

  localparam int unsigned PIX_DW        = 24;
  localparam int unsigned WIN_SIZE      = 3;
  localparam int unsigned DEF_IMG_WIDTH = 640;
  localparam int unsigned MIN_IMG_WIDTH = 3;

  function automatic int unsigned col_bits(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Simple dual-port line buffer, one line deep.
//   CLK   : clock
//   WE    : write enable, WADDR/WDATA : write port
//   RE    : read enable,  RADDR/RDATA : read port, registered (1-cycle latency)
// A read and a write to the same address in one cycle returns the old word.
// RDATA holds while RE is low. Contents are never reset.
module sobel_line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 24,
  parameter int unsigned AW    = 10
) (
  input  logic          CLK,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA,
  input  logic          RE,
  input  logic [AW-1:0] RADDR,
  output logic [DW-1:0] RDATA
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
    if (RE) RDATA <= mem[RADDR];
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel 3x3 window generator. Takes a raster pixel stream and emits, for every
// pixel at row>=2 and col>=2, the 3x3 neighbourhood ending at that pixel.
//   CLK, RESET (async, active low)
//   DIN / DIN_VALID / DIN_SOF / DIN_EOL : input pixel stream
//   D0xOUT : upper row (r-2), D1xOUT : middle row (r-1), D2xOUT : current row r
//            x2 = oldest column, x0 = newest column
//   DOUT_VALID / DOUT_SOF / DOUT_EOL : window qualifiers, 2 cycles after the beat
//   LEN_ERR : one-cycle pulse when a line length disagrees with IMG_WIDTH
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int unsigned DW        = PIX_DW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] DIN,
  input  logic          DIN_VALID,
  input  logic          DIN_SOF,
  input  logic          DIN_EOL,
  output logic [DW-1:0] D02OUT,
  output logic [DW-1:0] D01OUT,
  output logic [DW-1:0] D00OUT,
  output logic [DW-1:0] D12OUT,
  output logic [DW-1:0] D11OUT,
  output logic [DW-1:0] D10OUT,
  output logic [DW-1:0] D22OUT,
  output logic [DW-1:0] D21OUT,
  output logic [DW-1:0] D20OUT,
  output logic          DOUT_VALID,
  output logic          DOUT_SOF,
  output logic          DOUT_EOL,
  output logic          LEN_ERR
);

  localparam int unsigned   CW       = col_bits(IMG_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] EDGE_COL = CW'(WIN_SIZE - 1);
  localparam logic [1:0]    FULL_ROW = 2'(WIN_SIZE - 1);

  // Stage 0: position tracking
  logic [CW-1:0] col, col_eff, col_nxt;
  logic [1:0]    row, row_eff, row_nxt;
  logic          sof_pend, sof_pend_nxt;
  logic          last_col, wrap, len_bad, win_ok, sof_win;

  // SOF overrides the counters for its own beat. ROW saturates, so the first
  // window of a frame is tracked with a pending flag rather than ROW==2.
  always_comb begin
    col_eff      = DIN_SOF ? '0 : col;
    row_eff      = DIN_SOF ? '0 : row;
    last_col     = (col_eff == LAST_COL);
    wrap         = DIN_EOL || last_col;
    len_bad      = DIN_EOL != last_col;
    win_ok       = (row_eff == FULL_ROW) && (col_eff >= EDGE_COL);
    sof_win      = (DIN_SOF || sof_pend) && win_ok;
    sof_pend_nxt = (DIN_SOF || sof_pend) && !win_ok;
    col_nxt      = wrap ? '0 : col_eff + CW'(1);
    row_nxt      = (wrap && (row_eff != FULL_ROW)) ? row_eff + 2'd1 : row_eff;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      col      <= '0;
      row      <= '0;
      sof_pend <= 1'b1;
    end else if (DIN_VALID) begin
      col      <= col_nxt;
      row      <= row_nxt;
      sof_pend <= sof_pend_nxt;
    end
  end

  // Line buffer cascade: A holds row r-1, B holds row r-2.
  // B is written one cycle late, with A's read data, at the delayed address.
  logic [DW-1:0] a_q, b_q;
  logic          v1, ok1, sof1, eol1, err1;
  logic [DW-1:0] din1;
  logic [CW-1:0] col1;

  sobel_line_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW),
    .AW    (CW)
  ) u_line_a (
    .CLK   (CLK),
    .WE    (DIN_VALID),
    .WADDR (col_eff),
    .WDATA (DIN),
    .RE    (DIN_VALID),
    .RADDR (col_eff),
    .RDATA (a_q)
  );

  sobel_line_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW),
    .AW    (CW)
  ) u_line_b (
    .CLK   (CLK),
    .WE    (v1),
    .WADDR (col1),
    .WDATA (a_q),
    .RE    (DIN_VALID),
    .RADDR (col_eff),
    .RDATA (b_q)
  );

  // Stage 1: align pixel and flags with line buffer read data
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      v1   <= 1'b0;
      din1 <= '0;
      col1 <= '0;
      ok1  <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      v1 <= DIN_VALID;
      if (DIN_VALID) begin
        din1 <= DIN;
        col1 <= col_eff;
        ok1  <= win_ok;
        sof1 <= sof_win;
        eol1 <= wrap;
        err1 <= len_bad;
      end
    end
  end

  // Stage 2: shift the window on every aligned beat, including the first two
  // columns of a line, so the window is primed when COL reaches 2.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      D02OUT     <= '0;
      D01OUT     <= '0;
      D00OUT     <= '0;
      D12OUT     <= '0;
      D11OUT     <= '0;
      D10OUT     <= '0;
      D22OUT     <= '0;
      D21OUT     <= '0;
      D20OUT     <= '0;
      DOUT_VALID <= 1'b0;
      DOUT_SOF   <= 1'b0;
      DOUT_EOL   <= 1'b0;
      LEN_ERR    <= 1'b0;
    end else begin
      DOUT_VALID <= v1 && ok1;
      DOUT_SOF   <= v1 && sof1;
      DOUT_EOL   <= v1 && ok1 && eol1;
      LEN_ERR    <= v1 && err1;
      if (v1) begin
        D02OUT <= D01OUT;
        D01OUT <= D00OUT;
        D00OUT <= b_q;
        D12OUT <= D11OUT;
        D11OUT <= D10OUT;
        D10OUT <= a_q;
        D22OUT <= D21OUT;
        D21OUT <= D20OUT;
        D20OUT <= din1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

  localparam int W  = 8;
  localparam int NR = 64;

  typedef struct packed {
    logic v, sof, eol, err, wchk;
    logic [8:0][23:0] w;   // w[k*3+j] = Dkj
  } out_t;

  typedef struct {
    int r, c;
    logic [23:0] e02, e00, e22, e20;
    logic esof, eeol;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  // IMG_WIDTH = 8 instance
  logic [23:0] DIN = '0;
  logic DIN_VALID = 1'b0, DIN_SOF = 1'b0, DIN_EOL = 1'b0;
  logic [23:0] D02, D01, D00, D12, D11, D10, D22, D21, D20;
  logic DV, DS, DE, LE;

  sobel_window_gen #(.IMG_WIDTH(8), .DW(24)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_SOF(DIN_SOF), .DIN_EOL(DIN_EOL),
    .D02OUT(D02), .D01OUT(D01), .D00OUT(D00),
    .D12OUT(D12), .D11OUT(D11), .D10OUT(D10),
    .D22OUT(D22), .D21OUT(D21), .D20OUT(D20),
    .DOUT_VALID(DV), .DOUT_SOF(DS), .DOUT_EOL(DE), .LEN_ERR(LE)
  );

  // IMG_WIDTH = 3 instance
  logic [23:0] din3 = '0;
  logic dv3 = 1'b0, sof3 = 1'b0, eol3 = 1'b0;
  logic [23:0] e02_3, e01_3, e00_3, e12_3, e11_3, e10_3, e22_3, e21_3, e20_3;
  logic ov3, os3, oe3, le3;

  sobel_window_gen #(.IMG_WIDTH(3), .DW(24)) dut3 (
    .CLK(CLK), .RESET(RESET), .DIN(din3), .DIN_VALID(dv3),
    .DIN_SOF(sof3), .DIN_EOL(eol3),
    .D02OUT(e02_3), .D01OUT(e01_3), .D00OUT(e00_3),
    .D12OUT(e12_3), .D11OUT(e11_3), .D10OUT(e10_3),
    .D22OUT(e22_3), .D21OUT(e21_3), .D20OUT(e20_3),
    .DOUT_VALID(ov3), .DOUT_SOF(os3), .DOUT_EOL(oe3), .LEN_ERR(le3)
  );

  int tests = 0, fails = 0;
  int calls = 0, first_v = -1, consec = 0, nerr = 0;
  bit prev_v = 0;
  out_t cap[$];
  out_t exp_prev;
  vec_t tbl[12];

  // Reference model: the image as delivered, by true row and column
  logic [23:0] img  [NR][W];
  bit          imgv [NR][W];
  int          mrow, mcol;

  function automatic logic [23:0] px(input int r, input int c);
    return 24'((r << 4) | c);
  endfunction

  function automatic out_t sample8();
    out_t o;
    o = '0;
    o.v = DV; o.sof = DS; o.eol = DE; o.err = LE;
    o.w[0] = D00; o.w[1] = D01; o.w[2] = D02;
    o.w[3] = D10; o.w[4] = D11; o.w[5] = D12;
    o.w[6] = D20; o.w[7] = D21; o.w[8] = D22;
    return o;
  endfunction

  task automatic model_reset();
    mrow = 0; mcol = 0; exp_prev = '0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < W; j++) imgv[i][j] = 0;
  endtask

  // Expected outputs for one accepted beat. Windows that reference a pixel not
  // delivered in the current frame have unspecified contents (flags still checked).
  task automatic model_step(input logic [23:0] d, input logic sof, input logic eol);
    int r, c, rr, cc;
    bit last;
    out_t e;
    if (sof) begin mrow = 0; mcol = 0; end
    r = mrow; c = mcol;
    if (c == 0) for (int j = 0; j < W; j++) imgv[r % NR][j] = 0;
    img[r % NR][c] = d; imgv[r % NR][c] = 1;
    last = (c == W - 1);
    e = '0;
    e.err = (eol != last);
    if (r >= 2 && c >= 2) begin
      e.v = 1; e.sof = (r == 2 && c == 2); e.eol = eol || last; e.wchk = 1;
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) begin
          rr = (r - 2 + k) % NR; cc = c - j;
          e.w[k*3+j] = img[rr][cc];
          if (!imgv[rr][cc]) e.wchk = 0;
        end
    end
    if (eol || last) begin mcol = 0; mrow++; end
    else mcol++;
    exp_prev = e;
  endtask

  task automatic check_out(input string nm, input out_t got, input out_t e);
    tests++;
    if (got.v !== e.v || got.sof !== e.sof || got.eol !== e.eol || got.err !== e.err ||
        (e.v && e.wchk && got.w !== e.w)) begin
      fails++;
      $display("FAIL %s t=%0t: got v%b sof%b eol%b err%b win=%h, need v%b sof%b eol%b err%b win=%h (chk%b)",
               nm, $time, got.v, got.sof, got.eol, got.err, got.w,
               e.v, e.sof, e.eol, e.err, e.w, e.wchk);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int need);
    tests++;
    if (got != need) begin
      fails++;
      $display("FAIL %s: got %0d need %0d", nm, got, need);
    end
  endtask

  task automatic check_px(input string nm, input logic [23:0] got, input logic [23:0] need);
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s: got %h need %h", nm, got, need);
    end
  endtask

  task automatic drive(input logic [23:0] d, input logic v, input logic sof, input logic eol);
    out_t got;
    DIN = d; DIN_VALID = v; DIN_SOF = sof; DIN_EOL = eol;
    @(posedge CLK); #1;
    got = sample8();
    check_out("stream", got, exp_prev);
    calls++;
    if (got.v) begin
      cap.push_back(got);
      if (prev_v) consec++;
      if (first_v < 0) first_v = calls;
    end
    prev_v = got.v;
    if (got.err) nerr++;
    if (v) model_step(d, sof, eol);
    else exp_prev = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 0, 0, 0);
  endtask

  task automatic feed_row(input int r, input bit sof, input bit gap);
    for (int c = 0; c < W; c++) begin
      drive(px(r, c), 1, sof && c == 0, c == W - 1);
      if (gap) drive('0, 0, 0, 0);
    end
  endtask

  task automatic cmp_table(input string nm);
    check_int({nm, " window count"}, cap.size(), 12);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      tests++;
      if (cap[i].w[2] !== tbl[i].e02 || cap[i].w[0] !== tbl[i].e00 ||
          cap[i].w[8] !== tbl[i].e22 || cap[i].w[6] !== tbl[i].e20 ||
          cap[i].sof !== tbl[i].esof || cap[i].eol !== tbl[i].eeol) begin
        fails++;
        $display("FAIL %s win(%0d,%0d): got d02=%h d00=%h d22=%h d20=%h sof%b eol%b need %h %h %h %h sof%b eol%b",
                 nm, tbl[i].r, tbl[i].c, cap[i].w[2], cap[i].w[0], cap[i].w[8], cap[i].w[6],
                 cap[i].sof, cap[i].eol, tbl[i].e02, tbl[i].e00, tbl[i].e22, tbl[i].e20,
                 tbl[i].esof, tbl[i].eeol);
      end
    end
  endtask

  task automatic drive3(input logic [23:0] d, input logic v, input logic sof, input logic eol,
                        inout int nwin, inout int nle, inout out_t last);
    din3 = d; dv3 = v; sof3 = sof; eol3 = eol;
    @(posedge CLK); #1;
    if (le3) nle++;
    if (ov3) begin
      nwin++;
      last = '0;
      last.sof = os3; last.eol = oe3;
      last.w[0] = e00_3; last.w[2] = e02_3; last.w[6] = e20_3; last.w[8] = e22_3;
    end
  endtask

  initial begin
    out_t got, w3;
    int n3, nle3, tot;

    // Expected windows of the 8x4 ramp frame, oldest first
    for (int i = 0; i < 12; i++) begin
      tbl[i].r    = 2 + i / 6;
      tbl[i].c    = 2 + i % 6;
      tbl[i].e02  = px(tbl[i].r - 2, tbl[i].c - 2);
      tbl[i].e00  = px(tbl[i].r - 2, tbl[i].c);
      tbl[i].e22  = px(tbl[i].r, tbl[i].c - 2);
      tbl[i].e20  = px(tbl[i].r, tbl[i].c);
      tbl[i].esof = (tbl[i].r == 2 && tbl[i].c == 2);
      tbl[i].eeol = (tbl[i].c == W - 1);
    end

    // Reset state
    #1;
    got = sample8();
    tests++;
    if (got !== '0) begin fails++; $display("FAIL reset8: got %h need 0", got); end
    tests++;
    if ({ov3, os3, oe3, le3, e20_3, e00_3, e22_3} !== '0) begin
      fails++; $display("FAIL reset3: got v%b d20=%h need 0", ov3, e20_3);
    end
    repeat (3) @(posedge CLK);
    #3 RESET = 1'b1;
    model_reset();

    // Ramp frame, continuous
    cap.delete(); consec = 0;
    feed_row(0, 1, 0); feed_row(1, 0, 0); feed_row(2, 0, 0); feed_row(3, 0, 0);
    idle(3);
    cmp_table("ramp");

    // Ramp frame, valid toggling
    cap.delete(); consec = 0;
    feed_row(0, 1, 1); feed_row(1, 0, 1); feed_row(2, 0, 1); feed_row(3, 0, 1);
    idle(3);
    cmp_table("toggle");
    check_int("toggle consecutive valid", consec, 0);

    // Short line: row 1 ends at col 5
    cap.delete(); nerr = 0;
    feed_row(0, 1, 0);
    for (int c = 0; c < 6; c++) drive(px(1, c), 1, 0, c == 5);
    feed_row(2, 0, 0); feed_row(3, 0, 0);
    idle(3);
    check_int("short line len_err pulses", nerr, 1);
    check_int("short line first sof", (cap.size() > 0) ? int'(cap[0].sof) : -1, 1);
    check_px("short line first d20", (cap.size() > 0) ? cap[0].w[6] : 'x, px(2, 2));

    // One-pixel line from SOF+EOL on one beat
    cap.delete(); nerr = 0;
    drive(px(0, 0), 1, 1, 1);
    feed_row(1, 0, 0); feed_row(2, 0, 0);
    idle(3);
    check_int("sof+eol len_err pulses", nerr, 1);
    check_int("sof+eol window count", cap.size(), 6);
    check_px("sof+eol first d20", (cap.size() > 0) ? cap[0].w[6] : 'x, px(2, 2));

    // SOF mid-frame at pixel (2,4)
    feed_row(0, 1, 0); feed_row(1, 0, 0);
    for (int c = 0; c < 4; c++) drive(px(2, c), 1, 0, 0);
    drive(px(0, 0), 1, 1, 0);
    cap.delete();
    for (int c = 1; c < W; c++) drive(px(0, c), 1, 0, c == W - 1);
    feed_row(1, 0, 0); feed_row(2, 0, 0);
    idle(3);
    check_int("restart window count", cap.size(), 6);
    check_int("restart first sof", (cap.size() > 0) ? int'(cap[0].sof) : -1, 1);
    check_px("restart first d20", (cap.size() > 0) ? cap[0].w[6] : 'x, px(2, 2));

    // Reset asserted at pixel (3,3)
    feed_row(0, 1, 0); feed_row(1, 0, 0); feed_row(2, 0, 0);
    for (int c = 0; c < 3; c++) drive(px(3, c), 1, 0, 0);
    DIN = px(3, 3); DIN_VALID = 1; DIN_SOF = 0; DIN_EOL = 0;
    #2 RESET = 1'b0;
    #1 got = sample8();
    tests++;
    if (got !== '0) begin fails++; $display("FAIL midreset: got %h need 0", got); end
    DIN_VALID = 0;
    repeat (2) @(posedge CLK);
    #3 RESET = 1'b1;
    model_reset(); calls = 0; first_v = -1; prev_v = 0; cap.delete();
    feed_row(0, 0, 0); feed_row(1, 0, 0); feed_row(2, 0, 0);
    idle(3);
    check_int("first window after reset", first_v, 2 * W + 4);
    check_int("windows after reset", cap.size(), 6);

    // Randomized frames with random bubbles
    cap.delete();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < W; c++) begin
          while ($urandom_range(0, 2) == 0) drive('0, 0, 0, 0);
          drive(24'($urandom), 1, r == 0 && c == 0, c == W - 1);
        end
    idle(3);
    tot = cap.size();
    check_int("random window count", tot, 3 * 3 * 6);

    // IMG_WIDTH=3, single 3x3 frame
    n3 = 0; nle3 = 0; w3 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        drive3(px(r, c), 1, r == 0 && c == 0, c == 2, n3, nle3, w3);
    for (int i = 0; i < 3; i++) drive3('0, 0, 0, 0, n3, nle3, w3);
    check_int("w3 window count", n3, 1);
    check_int("w3 len_err pulses", nle3, 0);
    check_int("w3 sof", int'(w3.sof), 1);
    check_int("w3 eol", int'(w3.eol), 1);
    check_px("w3 d20", w3.w[6], px(2, 2));
    check_px("w3 d00", w3.w[0], px(0, 2));
    check_px("w3 d02", w3.w[2], px(0, 0));
    check_px("w3 d22", w3.w[8], px(2, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
